// File: rtl/blockade_input_pkg.sv
// Shared definitions for Blockade/Comotion input conditioning: modes, input bit map, coin FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package blockade_input_pkg;

    localparam logic [1:0] GAME_BLOCKADE = 2'd0;
    localparam logic [1:0] GAME_COMOTION = 2'd1;

    localparam int NUM_INPUTS  = 10;
    localparam int IN_P1_RIGHT = 0;
    localparam int IN_P1_LEFT  = 1;
    localparam int IN_P1_DOWN  = 2;
    localparam int IN_P1_UP    = 3;
    localparam int IN_P2_RIGHT = 4;
    localparam int IN_P2_LEFT  = 5;
    localparam int IN_P2_DOWN  = 6;
    localparam int IN_P2_UP    = 7;
    localparam int IN_COIN     = 8;
    localparam int IN_START    = 9;

    // The cabinet's boom switch is not wired on this platform.
    localparam logic BOOM = 1'b0;

    typedef enum logic [1:0] {
        COIN_IDLE    = 2'd0,
        COIN_PULSE   = 2'd1,
        COIN_LOCKOUT = 2'd2
    } coin_state_e;

    typedef struct packed {
        logic [7:0] in_1;
        logic [7:0] in_2;
        logic [7:0] in_4;
    } port_bytes_t;

    // Active-high joystick byte as the game core expects it, before inversion.
    function automatic logic [7:0] ctrl_byte(input logic [7:0] b);
        return {b[IN_P2_LEFT], b[IN_P2_DOWN], b[IN_P2_RIGHT], b[IN_P2_UP],
                b[IN_P1_LEFT], b[IN_P1_DOWN], b[IN_P1_RIGHT], b[IN_P1_UP]};
    endfunction

endpackage

// File: rtl/input_debounce.sv
// One raw input bit: 2-flop synchroniser, then a ce-ticked debouncer when INPUT_COND_DEBOUNCE_EN is defined.
// Latency: 2 clk_sys + DEBOUNCE_TICKS ce ticks (2 clk_sys when the debouncer is compiled out).
// Backpressure: none; the output always reflects the current accepted level.
module input_debounce #(
    parameter int DEBOUNCE_TICKS = 16
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic ce,
    input  logic din,
    output logic stable
);

    logic [1:0] sync;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], din};
        end
    end

`ifdef INPUT_COND_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [CW-1:0] cnt;
    logic          stable_q;

    // The counter only ever climbs to DEBOUNCE_TICKS-1 before being cleared, so it cannot wrap.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt      <= '0;
            stable_q <= 1'b0;
        end else if (ce) begin
            if (sync[1] != stable_q) begin
                if (cnt == CNT_LAST) begin
                    stable_q <= sync[1];
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign stable = stable_q;
`else
    logic unused_cfg;
    assign unused_cfg = ce ^ (DEBOUNCE_TICKS == 0);
    assign stable     = sync[1];
`endif

endmodule

// File: rtl/blockade_input_cond.sv
// Blockade/Comotion input conditioning: sync + debounce (INPUT_COND_DEBOUNCE_EN), port byte mapping, coin pulse.
// Latency: raw change to in_* is 2 + DEBOUNCE_TICKS + 1 cycles at ce=1 (3 cycles with debounce compiled out).
// Backpressure: none; outputs are registered and always valid, coin presses outside IDLE are dropped.
module blockade_input_cond
    import blockade_input_pkg::*;
#(
    parameter int DEBOUNCE_TICKS     = 16,
    parameter int COIN_PULSE_TICKS   = 64,
    parameter int COIN_LOCKOUT_TICKS = 256
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  logic [9:0] inputs,
    input  logic [1:0] game_mode,
    input  logic [2:0] dip_blockade,
    input  logic       dip_comotion,
    output logic [7:0] in_1,
    output logic [7:0] in_2,
    output logic [7:0] in_4,
    output logic       coin
);

    logic [NUM_INPUTS-1:0] db;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
        input_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_debounce (
            .clk_sys(clk_sys),
            .reset  (reset),
            .ce     (ce),
            .din    (inputs[i]),
            .stable (db[i])
        );
    end

    // Port byte mapping; mode and DIPs feed the register directly so they show up one edge later.
    logic [7:0]  ctrl;
    port_bytes_t bytes_nxt;
    port_bytes_t bytes_q;

    assign ctrl = ctrl_byte(db[7:0]);

    always_comb begin
        bytes_nxt = '1;
        case (game_mode)
            GAME_BLOCKADE: begin
                bytes_nxt.in_1 = ~{1'b0, dip_blockade, 1'b0, BOOM, 2'b00};
                bytes_nxt.in_2 = ~ctrl;
            end
            GAME_COMOTION: begin
                bytes_nxt.in_1 = ~ctrl;
                bytes_nxt.in_2 = ~{3'b000, db[IN_START], dip_comotion, BOOM, 2'b00};
                bytes_nxt.in_4 = ~ctrl;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bytes_q <= '1;
        end else begin
            bytes_q <= bytes_nxt;
        end
    end

    assign in_1 = bytes_q.in_1;
    assign in_2 = bytes_q.in_2;
    assign in_4 = bytes_q.in_4;

    // Coin pulse shaper, one counter shared by PULSE and LOCKOUT.
    localparam int CNT_MAX = (COIN_PULSE_TICKS > COIN_LOCKOUT_TICKS) ? COIN_PULSE_TICKS
                                                                     : COIN_LOCKOUT_TICKS;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_PULSE_TICKS - 1);
    localparam logic [CW-1:0] LOCK_END   = CW'(COIN_LOCKOUT_TICKS);

    coin_state_e coin_state;
    coin_state_e coin_state_nxt;
    logic [CW-1:0] coin_cnt;
    logic [CW-1:0] coin_cnt_nxt;
    logic [CW-1:0] lock_cnt_inc;
    logic          coin_db;
    logic          coin_prev;
    logic          coin_rise;
    logic          coin_q;

    assign coin_db      = db[IN_COIN];
    assign coin_rise    = coin_db & ~coin_prev;
    assign lock_cnt_inc = (ce && coin_cnt != LOCK_END) ? coin_cnt + 1'b1 : coin_cnt;

    always_comb begin
        coin_state_nxt = coin_state;
        coin_cnt_nxt   = coin_cnt;
        case (coin_state)
            COIN_IDLE: begin
                coin_cnt_nxt = '0;
                if (coin_rise) begin
                    coin_state_nxt = COIN_PULSE;
                end
            end
            COIN_PULSE: begin
                if (ce) begin
                    if (coin_cnt == PULSE_LAST) begin
                        coin_state_nxt = COIN_LOCKOUT;
                        coin_cnt_nxt   = '0;
                    end else begin
                        coin_cnt_nxt = coin_cnt + 1'b1;
                    end
                end
            end
            COIN_LOCKOUT: begin
                coin_cnt_nxt = lock_cnt_inc;
                // A coin still held here keeps us in LOCKOUT; only a fresh press after release counts.
                if (lock_cnt_inc == LOCK_END && !coin_db) begin
                    coin_state_nxt = COIN_IDLE;
                    coin_cnt_nxt   = '0;
                end
            end
            default: begin
                coin_state_nxt = COIN_IDLE;
                coin_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            coin_state <= COIN_IDLE;
            coin_cnt   <= '0;
            coin_prev  <= 1'b0;
            coin_q     <= 1'b0;
        end else begin
            coin_state <= coin_state_nxt;
            coin_cnt   <= coin_cnt_nxt;
            coin_prev  <= coin_db;
            coin_q     <= (coin_state_nxt == COIN_PULSE);
        end
    end

    assign coin = coin_q;

endmodule

// File: tb/tb_blockade_input_cond.sv
// Scoreboard bench for blockade_input_cond: stimulus queues expected output snapshots with their cycle stamp.
// Latency: n/a. Backpressure: n/a. Honours INPUT_COND_DEBOUNCE_EN to pick the debounce or direct timing.
module tb_blockade_input_cond;

    localparam int DEB = 4;
    localparam int PUL = 8;
    localparam int LCK = 16;
`ifdef INPUT_COND_DEBOUNCE_EN
    localparam int LAT = 2 + DEB + 1;
`else
    localparam int LAT = 3;
`endif

    logic       clk_sys;
    logic       reset;
    logic       ce;
    logic [9:0] inputs;
    logic [1:0] game_mode;
    logic [2:0] dip_blockade;
    logic       dip_comotion;
    logic [7:0] in_1;
    logic [7:0] in_2;
    logic [7:0] in_4;
    logic       coin;

    blockade_input_cond #(
        .DEBOUNCE_TICKS    (DEB),
        .COIN_PULSE_TICKS  (PUL),
        .COIN_LOCKOUT_TICKS(LCK)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ce          (ce),
        .inputs      (inputs),
        .game_mode   (game_mode),
        .dip_blockade(dip_blockade),
        .dip_comotion(dip_comotion),
        .in_1        (in_1),
        .in_2        (in_2),
        .in_4        (in_4),
        .coin        (coin)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [24:0] val;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [24:0] last;
    bit          armed = 1'b0;

    task automatic push(input int dly, input logic [7:0] i1, input logic [7:0] i2,
                        input logic [7:0] i4, input logic co, input string nm);
        exp_t e;
        e.cyc  = cyc + dly;
        e.val  = {i1, i2, i4, co};
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Monitor: every change of the output bundle must match the next queued snapshot and its cycle.
    always @(negedge clk_sys) begin : mon
        logic [24:0] obs;
        exp_t        e;
        obs = {in_1, in_2, in_4, coin};
        if (!armed || obs !== last) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got in_1=%h in_2=%h in_4=%h coin=%b, want no change",
                         cyc, in_1, in_2, in_4, coin);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.val !== obs) begin
                    errors++;
                    $display("FAIL %s: got cyc=%0d {in_1,in_2,in_4,coin}=%h, want cyc=%0d value=%h",
                             e.name, cyc, obs, e.cyc, e.val);
                end
            end
            last  = obs;
            armed = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        ce           = 1'b1;
        inputs       = '0;
        game_mode    = 2'd0;
        dip_blockade = 3'b000;
        dip_comotion = 1'b0;
        push(1, 8'hFF, 8'hFF, 8'hFF, 1'b0, "reset_state");
        tick(3);
        reset = 1'b0;
        tick(2);

        // Mode 0 joystick mapping, several patterns
        inputs = 10'h001; push(LAT, 8'hFF, 8'hFD, 8'hFF, 1'b0, "p1_right"); tick(LAT + 2);
        inputs = 10'h0F0; push(LAT, 8'hFF, 8'h0F, 8'hFF, 1'b0, "p2_all");   tick(LAT + 2);
        inputs = 10'h00F; push(LAT, 8'hFF, 8'hF0, 8'hFF, 1'b0, "p1_all");   tick(LAT + 2);
        inputs = 10'h042; push(LAT, 8'hFF, 8'hB7, 8'hFF, 1'b0, "p1l_p2d");  tick(LAT + 2);
        inputs = 10'h000; push(LAT, 8'hFF, 8'hFF, 8'hFF, 1'b0, "release");  tick(LAT + 2);

`ifdef INPUT_COND_DEBOUNCE_EN
        // Short glitch must be ignored; a later full press then takes the full debounce time
        inputs[3] = 1'b1; tick(3);
        inputs[3] = 1'b0; tick(12);
        inputs[3] = 1'b1; push(LAT, 8'hFF, 8'hFE, 8'hFF, 1'b0, "p1_up_after_glitch"); tick(LAT + 2);
        inputs[3] = 1'b0; push(LAT, 8'hFF, 8'hFF, 8'hFF, 1'b0, "p1_up_release");      tick(LAT + 2);
`else
        // Single-cycle pulses pass straight through as single-cycle port changes
        inputs[4] = 1'b1;
        push(3, 8'hFF, 8'hDF, 8'hFF, 1'b0, "pulse_p2_right_on");
        push(4, 8'hFF, 8'hFF, 8'hFF, 1'b0, "pulse_p2_right_off");
        tick(1); inputs[4] = 1'b0; tick(6);
        inputs[2] = 1'b1;
        push(3, 8'hFF, 8'hFB, 8'hFF, 1'b0, "pulse_p1_down_on");
        push(4, 8'hFF, 8'hFF, 8'hFF, 1'b0, "pulse_p1_down_off");
        tick(1); inputs[2] = 1'b0; tick(6);
`endif

        // DIP and mode changes land on the next edge
        dip_blockade = 3'b101; push(1, 8'hAF, 8'hFF, 8'hFF, 1'b0, "dip_101"); tick(2);
        dip_blockade = 3'b010; push(1, 8'hDF, 8'hFF, 8'hFF, 1'b0, "dip_010"); tick(2);
        inputs = 10'h201; push(LAT, 8'hDF, 8'hFD, 8'hFF, 1'b0, "start_ignored_mode0"); tick(LAT + 2);
        game_mode = 2'd1;    push(1, 8'hFD, 8'hEF, 8'hFD, 1'b0, "mode1_dipc0"); tick(2);
        dip_comotion = 1'b1; push(1, 8'hFD, 8'hE7, 8'hFD, 1'b0, "mode1_dipc1"); tick(2);
        game_mode = 2'd3;    push(1, 8'hFF, 8'hFF, 8'hFF, 1'b0, "mode3");       tick(2);
        game_mode = 2'd2;    tick(2);
        game_mode = 2'd0;    push(1, 8'hDF, 8'hFD, 8'hFF, 1'b0, "mode0_back");  tick(2);
        inputs = 10'h000;    push(LAT, 8'hDF, 8'hFF, 8'hFF, 1'b0, "mode0_idle"); tick(LAT + 2);
        game_mode = 2'd1;    push(1, 8'hFF, 8'hF7, 8'hFF, 1'b0, "mode1_idle");  tick(2);
        inputs = 10'h0F0;    push(LAT, 8'h0F, 8'hF7, 8'h0F, 1'b0, "mode1_p2_all"); tick(LAT + 2);
        inputs = 10'h000;    push(LAT, 8'hFF, 8'hF7, 8'hFF, 1'b0, "mode1_release"); tick(LAT + 2);
        game_mode = 2'd0;    push(1, 8'hDF, 8'hFF, 8'hFF, 1'b0, "mode0_final"); tick(2);

        // Coin pulse width, then a press during lockout is dropped
        inputs[8] = 1'b1;
        push(LAT,       8'hDF, 8'hFF, 8'hFF, 1'b1, "coin_rise");
        push(LAT + PUL, 8'hDF, 8'hFF, 8'hFF, 1'b0, "coin_fall");
        tick(6); inputs[8] = 1'b0;
        tick(LAT + PUL + 5 - 6);
        inputs[8] = 1'b1; tick(6); inputs[8] = 1'b0;
        tick(40);

        // Coin held through lockout end gives one pulse; release and re-press gives another
        inputs[8] = 1'b1;
        push(LAT,       8'hDF, 8'hFF, 8'hFF, 1'b1, "held_coin_rise");
        push(LAT + PUL, 8'hDF, 8'hFF, 8'hFF, 1'b0, "held_coin_fall");
        tick(LAT + PUL + LCK + 10);
        inputs[8] = 1'b0; tick(LAT + 3);
        inputs[8] = 1'b1;
        push(LAT,       8'hDF, 8'hFF, 8'hFF, 1'b1, "repress_rise");
        push(LAT + PUL, 8'hDF, 8'hFF, 8'hFF, 1'b0, "repress_fall");
        tick(6); inputs[8] = 1'b0;
        tick(LAT + PUL + LCK + 10);

        // Pulse stretches by the number of cycles ce is held low
        inputs[8] = 1'b1;
        push(LAT,           8'hDF, 8'hFF, 8'hFF, 1'b1, "ce_gap_rise");
        push(LAT + PUL + 5, 8'hDF, 8'hFF, 8'hFF, 1'b0, "ce_gap_fall");
        tick(LAT); ce = 1'b0;
        tick(5);   ce = 1'b1;
        tick(3);   inputs[8] = 1'b0;
        tick(PUL + LCK + LAT + 10);

        // Reset three ticks into the pulse drops coin and port bytes at that edge
        inputs[8] = 1'b1;
        push(LAT,     8'hDF, 8'hFF, 8'hFF, 1'b1, "rst_coin_rise");
        push(LAT + 3, 8'hFF, 8'hFF, 8'hFF, 1'b0, "rst_mid_pulse");
        push(LAT + 5, 8'hDF, 8'hFF, 8'hFF, 1'b0, "rst_release");
        tick(LAT + 2);
        reset = 1'b1; inputs[8] = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(30);
        inputs[8] = 1'b1;
        push(LAT,       8'hDF, 8'hFF, 8'hFF, 1'b1, "post_rst_rise");
        push(LAT + PUL, 8'hDF, 8'hFF, 8'hFF, 1'b0, "post_rst_fall");
        tick(6); inputs[8] = 1'b0;
        tick(PUL + LCK + LAT + 10);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected outputs not seen, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
